// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: multiply/divide sequencer that owns every HI/LO register write.
// Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO. MULT/DIV run as 32-step radix-2
// shift-add multiply / restoring divide, then write HI and LO together for one cycle.
// MTHI/MTLO write through with a one-cycle latency. All outputs are registered.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   operation request (accepted only while busy = 0)
//   md_op      in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   flush      in   abort any in-flight operation, no HI/LO write
//   rs_data    in   multiplicand / dividend / MTHI-MTLO source
//   rt_data    in   multiplier / divisor
//   busy       out  multiply or divide in progress
//   hi_write   out  HI write strobe
//   lo_write   out  LO write strobe
//   hi_wdata   out  HI write data
//   lo_wdata   out  LO write data
module hilo_md_ctrl #(
    parameter logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        hi_write,
    output logic        lo_write,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] work_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd_q;      // multiplicand or divisor magnitude
    logic        neg_lo_q;    // negate product / quotient at the end
    logic        neg_hi_q;    // negate remainder at the end
    logic        div_zero_q;

    logic [31:0] rs_abs, rt_abs;
    logic        op_signed;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_res;
    logic [32:0] div_shift;
    logic        div_ok;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [31:0] div_q, div_r;

    always_comb begin
        op_signed = ~md_op[0];
        rs_abs    = (op_signed && rs_data[31]) ? -rs_data : rs_data;
        rt_abs    = (op_signed && rt_data[31]) ? -rt_data : rt_data;

        // Shift-add: add multiplicand into the upper half when the current multiplier bit
        // is set, then shift the whole 65-bit value right by one.
        mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next = {mul_sum, work_q[31:1]};
        mul_res  = neg_lo_q ? -mul_next : mul_next;

        // Restoring divide: shift the next dividend bit into the remainder and keep the
        // subtraction only if it does not go negative. A zero divisor always "succeeds",
        // which leaves the raw dividend in the remainder after 32 steps.
        div_shift = work_q[63:31];
        div_ok    = div_shift >= {1'b0, opnd_q};
        div_rem   = div_shift[31:0] - opnd_q;
        div_next  = div_ok ? {div_rem, work_q[30:0], 1'b1} : {work_q[62:0], 1'b0};
        div_q     = div_zero_q ? DIV_ZERO_Q
                  : (neg_lo_q ? -div_next[31:0] : div_next[31:0]);
        div_r     = neg_hi_q ? -div_next[63:32] : div_next[63:32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 5'd0;
            work_q     <= 64'd0;
            opnd_q     <= 32'd0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            busy       <= 1'b0;
            hi_write   <= 1'b0;
            lo_write   <= 1'b0;
            hi_wdata   <= 32'd0;
            lo_wdata   <= 32'd0;
        end else if (flush) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            busy     <= 1'b0;
            hi_write <= 1'b0;
            lo_write <= 1'b0;
        end else begin
            hi_write <= 1'b0;
            lo_write <= 1'b0;
            unique case (state_q)
                StMul: begin
                    work_q <= mul_next;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q  <= StDone;
                        busy     <= 1'b0;
                        hi_write <= 1'b1;
                        lo_write <= 1'b1;
                        hi_wdata <= mul_res[63:32];
                        lo_wdata <= mul_res[31:0];
                    end
                end
                StDiv: begin
                    work_q <= div_next;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q  <= StDone;
                        busy     <= 1'b0;
                        hi_write <= 1'b1;
                        lo_write <= 1'b1;
                        hi_wdata <= div_r;
                        lo_wdata <= div_q;
                    end
                end
                default: begin
                    // StIdle and StDone both accept a new request.
                    state_q <= StIdle;
                    if (start) begin
                        unique case (md_op)
                            3'd0, 3'd1: begin
                                state_q    <= StMul;
                                busy       <= 1'b1;
                                cnt_q      <= 5'd0;
                                work_q     <= {32'd0, rt_abs};
                                opnd_q     <= rs_abs;
                                neg_lo_q   <= op_signed & (rs_data[31] ^ rt_data[31]);
                                neg_hi_q   <= 1'b0;
                                div_zero_q <= 1'b0;
                            end
                            3'd2, 3'd3: begin
                                state_q    <= StDiv;
                                busy       <= 1'b1;
                                cnt_q      <= 5'd0;
                                opnd_q     <= rt_abs;
                                div_zero_q <= (rt_data == 32'd0);
                                if (rt_data == 32'd0) begin
                                    work_q   <= {32'd0, rs_data};
                                    neg_lo_q <= 1'b0;
                                    neg_hi_q <= 1'b0;
                                end else begin
                                    work_q   <= {32'd0, rs_abs};
                                    neg_lo_q <= op_signed & (rs_data[31] ^ rt_data[31]);
                                    neg_hi_q <= op_signed & rs_data[31];
                                end
                            end
                            3'd4: begin
                                hi_write <= 1'b1;
                                hi_wdata <= rs_data;
                            end
                            3'd5: begin
                                lo_write <= 1'b1;
                                lo_wdata <= rs_data;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
module tb_hilo_md_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic        flush = 1'b0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        busy, hi_write, lo_write;
    logic [31:0] hi_wdata, lo_wdata;

    int n_pass = 0;
    int n_total = 0;

    hilo_md_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .flush    (flush),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .busy     (busy),
        .hi_write (hi_write),
        .lo_write (lo_write),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
    function automatic void ref_op(input logic [2:0] op, input logic [31:0] rs,
                                   input logic [31:0] rt, output logic [31:0] hi,
                                   output logic [31:0] lo);
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        ua = {32'd0, rs};
        ub = {32'd0, rt};
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            3'd0: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
            3'd1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
            3'd2, 3'd3: begin
                if (rt == 32'd0) begin
                    hi = rs;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 3'd2) begin
                    sp = sa / sb; lo = sp[31:0];
                    sp = sa % sb; hi = sp[31:0];
                end else begin
                    up = ua / ub; lo = up[31:0];
                    up = ua % ub; hi = up[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        start   = 1'b1;
        md_op   = op;
        rs_data = rs;
        rt_data = rt;
    endtask

    // Called at the negedge where issue() was driven. kill_at >= 0 aborts on that busy
    // cycle with flush (kind 0) or reset (kind 1). b2b issues the next op in the DONE cycle.
    task automatic run(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input int kill_at, input int kill_kind, input bit b2b,
                       input logic [2:0] nop, input logic [31:0] nrs, input logic [31:0] nrt);
        logic [31:0] eh, el;
        ref_op(op, rs, rt, eh, el);
        @(negedge clk);
        start = 1'b0;
        if (op == 3'd4 || op == 3'd5) begin
            chk("mt_flags", {61'd0, busy, hi_write, lo_write},
                {61'd0, 1'b0, op == 3'd4, op == 3'd5});
            chk("mt_data", op == 3'd4 ? hi_wdata : lo_wdata, rs);
            @(negedge clk);
            chk("mt_clear", {62'd0, hi_write, lo_write}, 64'd0);
        end else if (op >= 3'd6) begin
            chk("nop_flags", {61'd0, busy, hi_write, lo_write}, 64'd0);
        end else begin
            for (int i = 0; i < 32; i++) begin
                chk($sformatf("busy_c%0d", i), {61'd0, busy, hi_write, lo_write}, 64'd4);
                if (i == kill_at) begin
                    if (kill_kind == 1) reset = 1'b1;
                    else flush = 1'b1;
                    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
                    @(negedge clk);
                    reset = 1'b0;
                    flush = 1'b0;
                    start = 1'b0;
                    chk("kill_flags", {61'd0, busy, hi_write, lo_write}, 64'd0);
                    if (kill_kind == 1) chk("kill_rst_data", {hi_wdata, lo_wdata}, 64'd0);
                    for (int j = 0; j < 40; j++) begin
                        chk("kill_nostrobe", {61'd0, busy, hi_write, lo_write}, 64'd0);
                        @(negedge clk);
                    end
                    return;
                end
                if (i == 5) issue(3'd4, 32'h5555_AAAA, 32'd0);  // must be ignored
                if (i == 6) start = 1'b0;
                @(negedge clk);
            end
            chk("done_flags", {61'd0, busy, hi_write, lo_write}, 64'd3);
            chk("done_hi", {32'd0, hi_wdata}, {32'd0, eh});
            chk("done_lo", {32'd0, lo_wdata}, {32'd0, el});
            if (b2b) begin
                issue(nop, nrs, nrt);
                return;
            end
            @(negedge clk);
            chk("post_clear", {61'd0, busy, hi_write, lo_write}, 64'd0);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        // Hold reset for a few cycles, then check reset state.
        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, hi_write, lo_write, hi_wdata, lo_wdata}, 67'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", {61'd0, busy, hi_write, lo_write}, 64'd0);

        // Directed cases.
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        run(3'd0, 32'hFFFF_FFFD, 32'd5, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        run(3'd2, 32'hFFFF_FFF9, 32'd2, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd3, 32'd7, 32'd0);
        run(3'd3, 32'd7, 32'd0, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd2, 32'hFFFF_FFF0, 32'd0);
        run(3'd2, 32'hFFFF_FFF0, 32'd0, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd4, 32'h1234_5678, 32'd0);
        run(3'd4, 32'h1234_5678, 32'd0, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd6, 32'h1111_1111, 32'd0);
        run(3'd6, 32'h1111_1111, 32'd0, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);

        // Flush, then reset, on the 10th busy cycle; a following MTLO must still work.
        issue(3'd0, 32'd1234, 32'd5678);
        run(3'd0, 32'd1234, 32'd5678, 9, 0, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd5, 32'hCAFE_F00D, 32'd0);
        run(3'd5, 32'hCAFE_F00D, 32'd0, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd3, 32'd1000, 32'd7);
        run(3'd3, 32'd1000, 32'd7, 9, 1, 1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd5, 32'h0BAD_F00D, 32'd0);
        run(3'd5, 32'h0BAD_F00D, 32'd0, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);

        // Back-to-back: MULT accepted in the DONE cycle of a DIVU.
        issue(3'd3, 32'd100, 32'd9);
        run(3'd3, 32'd100, 32'd9, -1, 0, 1'b1, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);

        // Randomized operations, biased toward corner operands.
        for (int k = 0; k < 24; k++) begin
            rop = 3'($urandom_range(7, 0));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(5, 0))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = {28'd0, rb[3:0]};
                default: ;
            endcase
            issue(rop, ra, rb);
            run(rop, ra, rb, -1, 0, 1'b0, 3'd0, 32'd0, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
